// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready channel feeding the program loader.
// master drives in_data/in_valid; slave (the loader) returns in_ready.
interface prog_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/prog_loader.sv
// Instruction-memory program loader: assembles little-endian words from a
// byte stream, writes them through the core program port, then releases it.
// Ports: clk, reset (async active-low), start, s (byte stream, slave),
//   ProgMode/Addr_Prog/Data_Prog/Prog_we (program port), cpu_reset,
//   busy, done, error.
// Optional macro PROG_LOADER_CHECKSUM_EN: expect a trailing XOR checksum byte.
module prog_loader #(
   parameter int WORD_W   = 32,
   parameter int ADDR_W   = 8,
   parameter int RST_HOLD = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   prog_loader_if.slave      s,
   output logic              ProgMode,
   output logic [ADDR_W-1:0] Addr_Prog,
   output logic [WORD_W-1:0] Data_Prog,
   output logic              Prog_we,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int          BPW   = WORD_W / 8;
   localparam int          BW    = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE, S_HDR0, S_HDR1, S_DATA,
      S_CKSUM, S_REL, S_RUN, S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        lo_q, lo_d;
   logic [15:0]       n_q, n_d;
   logic [15:0]       widx_q, widx_d;
   logic [BW-1:0]     bidx_q, bidx_d;
   logic [WORD_W-1:0] asm_q, asm_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic              we_q, we_d;
   logic [3:0]        hold_q, hold_d;
   logic [7:0]        csum_q, csum_d;

   logic              xfer;
   logic [WORD_W-1:0] merged;
   logic [15:0]       hdr_n;
   logic              hdr_ok;
   logic              last_byte;
   logic              last_word;

   assign s.in_ready = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                       (state_q == S_DATA) || (state_q == S_CKSUM);
   assign xfer      = s.in_valid && s.in_ready;
   assign hdr_n     = {s.in_data, lo_q};
   assign hdr_ok    = (hdr_n != 16'd0) && ({16'd0, hdr_n} <= DEPTH);
   assign last_byte = (bidx_q == BW'(BPW - 1));
   assign last_word = (widx_q == n_q - 16'd1);

   // Current byte dropped into its little-endian lane of the partial word.
   always_comb begin
      merged = asm_q;
      merged[8*int'(bidx_q) +: 8] = s.in_data;
   end

   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      n_d     = n_q;
      widx_d  = widx_q;
      bidx_d  = bidx_q;
      asm_d   = asm_q;
      wdata_d = wdata_q;
      waddr_d = waddr_q;
      we_d    = 1'b0;
      hold_d  = hold_q;
      csum_d  = csum_q;
      unique case (state_q)
         S_IDLE, S_RUN, S_ERR: begin
            if (start) begin
               state_d = S_HDR0;
               widx_d  = '0;
               bidx_d  = '0;
               asm_d   = '0;
               csum_d  = '0;
            end
         end
         S_HDR0: begin
            if (xfer) begin
               lo_d    = s.in_data;
               state_d = S_HDR1;
            end
         end
         S_HDR1: begin
            if (xfer) begin
               n_d     = hdr_n;
               state_d = hdr_ok ? S_DATA : S_ERR;
            end
         end
         S_DATA: begin
            if (xfer) begin
               csum_d = csum_q ^ s.in_data;
               if (last_byte) begin
                  we_d    = 1'b1;
                  wdata_d = merged;
                  waddr_d = widx_q[ADDR_W-1:0];
                  widx_d  = widx_q + 16'd1;
                  bidx_d  = '0;
                  asm_d   = '0;
                  if (last_word) begin
                     hold_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                     state_d = S_CKSUM;
`else
                     state_d = S_REL;
`endif
                  end
               end else begin
                  asm_d  = merged;
                  bidx_d = bidx_q + BW'(1);
               end
            end
         end
         S_CKSUM: begin
`ifdef PROG_LOADER_CHECKSUM_EN
            if (xfer)
               state_d = (s.in_data == csum_q) ? S_REL : S_ERR;
`else
            state_d = S_ERR;
`endif
         end
         S_REL: begin
            // ProgMode is already high; keep the core held RST_HOLD cycles.
            if (hold_q == 4'(RST_HOLD - 1))
               state_d = S_RUN;
            else
               hold_d = hold_q + 4'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         lo_q    <= '0;
         n_q     <= '0;
         widx_q  <= '0;
         bidx_q  <= '0;
         asm_q   <= '0;
         wdata_q <= '0;
         waddr_q <= '0;
         we_q    <= 1'b0;
         hold_q  <= '0;
         csum_q  <= '0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         n_q     <= n_d;
         widx_q  <= widx_d;
         bidx_q  <= bidx_d;
         asm_q   <= asm_d;
         wdata_q <= wdata_d;
         waddr_q <= waddr_d;
         we_q    <= we_d;
         hold_q  <= hold_d;
         csum_q  <= csum_d;
      end
   end

   assign ProgMode  = (state_q == S_REL) || (state_q == S_RUN);
   assign cpu_reset = (state_q != S_RUN);
   assign busy      = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                      (state_q == S_DATA) || (state_q == S_CKSUM) ||
                      (state_q == S_REL);
   assign done      = (state_q == S_RUN);
   assign error     = (state_q == S_ERR);
   assign Addr_Prog = waddr_q;
   assign Data_Prog = wdata_q;
   assign Prog_we   = we_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a stream-parsing
// reference model; follows PROG_LOADER_CHECKSUM_EN like the design.
module tb_prog_loader;
   localparam int WORD_W   = 32;
   localparam int ADDR_W   = 8;
   localparam int RST_HOLD = 2;
   localparam int BPW      = WORD_W / 8;
   localparam int DEPTH    = 1 << ADDR_W;
`ifdef PROG_LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              ProgMode;
   logic [ADDR_W-1:0] Addr_Prog;
   logic [WORD_W-1:0] Data_Prog;
   logic              Prog_we;
   logic              cpu_reset;
   logic              busy;
   logic              done;
   logic              error;

   prog_loader_if sif ();

   prog_loader #(
      .WORD_W(WORD_W), .ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .s(sif.slave),
      .ProgMode(ProgMode), .Addr_Prog(Addr_Prog),
      .Data_Prog(Data_Prog), .Prog_we(Prog_we),
      .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]        st[$];
   int                exp_a[$];
   logic [WORD_W-1:0] exp_d[$];
   int                obs_a[$];
   logic [WORD_W-1:0] obs_d[$];

   always @(negedge clk) begin
      if (Prog_we) begin
         obs_a.push_back(int'(Addr_Prog));
         obs_d.push_back(Data_Prog);
      end
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Parse the stream as the loader should: expected writes, bytes consumed,
   // and whether the load ends running (1) or in error (0).
   task automatic model(output int used, output bit ok, output int n);
      logic [7:0]        x;
      logic [WORD_W-1:0] w;
      exp_a.delete();
      exp_d.delete();
      n = int'(st[0]) + 256 * int'(st[1]);
      if (n < 1 || n > DEPTH) begin
         used = 2;
         ok   = 1'b0;
         return;
      end
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
         w = '0;
         for (int k = 0; k < BPW; k++) begin
            w = w | (WORD_W'(st[2 + i*BPW + k]) << (8*k));
            x = x ^ st[2 + i*BPW + k];
         end
         exp_a.push_back(i % DEPTH);
         exp_d.push_back(w);
      end
      used = 2 + n * BPW;
      ok   = 1'b1;
      if (CK) begin
         ok   = (st[used] == x);
         used = used + 1;
      end
   endtask

   task automatic make_stream(input int n, input bit bad);
      logic [7:0] x = 8'h00;
      logic [7:0] b;
      st.delete();
      st.push_back(8'(n));
      st.push_back(8'(n >> 8));
      for (int i = 0; i < n * BPW; i++) begin
         b = 8'($urandom);
         x = x ^ b;
         st.push_back(b);
      end
      if (CK) st.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
   endtask

   task automatic send_byte(input logic [7:0] b, output bit to);
      int t = 0;
      to = 1'b0;
      sif.in_data  = b;
      sif.in_valid = 1'b1;
      while (!sif.in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) begin
         check("in_ready_timeout", 0, 1);
         sif.in_valid = 1'b0;
         to = 1'b1;
         return;
      end
      @(negedge clk);
      sif.in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_load(input string tag, input int gapmax);
      int used, n, lastp;
      bit ok, to;
      model(used, ok, n);
      obs_a.delete();
      obs_d.delete();
      pulse_start();
      check({tag, "_start_pm"}, ProgMode, 0);
      check({tag, "_start_crst"}, cpu_reset, 1);
      check({tag, "_start_rdy"}, sif.in_ready, 1);
      lastp = ok || used > 2 ? 2 + n * BPW - 1 : -1;
      for (int i = 0; i < used; i++) begin
         repeat ($urandom_range(0, gapmax)) @(negedge clk);
         send_byte(st[i], to);
         if (to) return;
         if (i == lastp) begin
            check({tag, "_last_we"}, Prog_we, 1);
            if (CK) check({tag, "_last_ck_rdy"}, sif.in_ready, 1);
            else    check({tag, "_last_pm"}, ProgMode, 1);
         end
      end
      if (ok) begin
         check({tag, "_rel_pm"}, ProgMode, 1);
         check({tag, "_rel_crst"}, cpu_reset, 1);
         repeat (RST_HOLD - 1) @(negedge clk);
         check({tag, "_hold_crst"}, cpu_reset, 1);
         @(negedge clk);
         check({tag, "_run_crst"}, cpu_reset, 0);
         check({tag, "_run_done"}, done, 1);
         check({tag, "_run_busy"}, busy, 0);
      end else begin
         check({tag, "_err"}, error, 1);
         check({tag, "_err_pm"}, ProgMode, 0);
         check({tag, "_err_crst"}, cpu_reset, 1);
         check({tag, "_err_done"}, done, 0);
         check({tag, "_err_rdy"}, sif.in_ready, 0);
      end
      repeat (2) @(negedge clk);
      check({tag, "_nwrites"}, obs_a.size(), exp_a.size());
      if (obs_a.size() == exp_a.size()) begin
         for (int i = 0; i < exp_a.size(); i++) begin
            check({tag, "_addr"}, obs_a[i], exp_a[i]);
            check({tag, "_data"}, obs_d[i], exp_d[i]);
         end
         if (exp_d.size() > 0)
            check({tag, "_data_hold"}, Data_Prog, exp_d[exp_d.size()-1]);
      end
   endtask

   task automatic plan_stream(input bit bad);
      logic [7:0] p[14] = '{8'h03, 8'h00, 8'h07, 8'h00, 8'h20, 8'h10,
                            8'h08, 8'h00, 8'h40, 8'h10, 8'h01, 8'h00,
                            8'h22, 8'h34};
      st.delete();
      foreach (p[i]) st.push_back(p[i]);
      if (CK) st.push_back(bad ? 8'h79 : 8'h78);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit to;
      int wcnt;
      sif.in_data  = 8'h00;
      sif.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pm", ProgMode, 0);
      check("rst_crst", cpu_reset, 1);
      check("rst_we", Prog_we, 0);
      check("rst_addr", Addr_Prog, 0);
      check("rst_data", Data_Prog, 0);
      check("rst_rdy", sif.in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", error, 0);
      reset = 1'b1;
      @(negedge clk);

      plan_stream(1'b0);
      run_load("plan", 0);
      if (obs_d.size() == 3) begin
         check("plan_w0", obs_d[0], 32'd270532615);
         check("plan_w1", obs_d[1], 32'd272629768);
         check("plan_w2", obs_d[2], 32'd874643457);
         check("plan_a2", obs_a[2], 2);
      end

      if (CK) begin
         plan_stream(1'b1);
         run_load("badck", 0);
      end

      st = '{8'h00, 8'h00};
      run_load("hdr0", 1);
      st = '{8'h01, 8'h01};
      run_load("hdr257", 1);

      plan_stream(1'b0);
      run_load("gaps", 3);

      // Abort in the middle of word 2.
      plan_stream(1'b0);
      obs_a.delete();
      obs_d.delete();
      pulse_start();
      for (int i = 0; i < 12; i++) begin
         send_byte(st[i], to);
      end
      wcnt = obs_a.size();
      check("mid_writes", wcnt, 2);
      sif.in_valid = 1'b1;
      sif.in_data  = 8'hAA;
      reset = 1'b0;
      #1;
      check("mid_pm", ProgMode, 0);
      check("mid_crst", cpu_reset, 1);
      check("mid_rdy", sif.in_ready, 0);
      check("mid_busy", busy, 0);
      check("mid_addr", Addr_Prog, 0);
      check("mid_data", Data_Prog, 0);
      check("mid_we", Prog_we, 0);
      repeat (4) @(negedge clk);
      check("mid_nowe", obs_a.size(), wcnt);
      sif.in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      plan_stream(1'b0);
      run_load("reload", 1);

      make_stream(1, 1'b0);
      run_load("one_word", 0);

      make_stream(DEPTH, 1'b0);
      run_load("full", 0);

      for (int r = 0; r < 8; r++) begin
         make_stream($urandom_range(1, 6), CK && ($urandom_range(0, 3) == 0));
         run_load("rand", 3);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
